ds_arbiter: RTL and testbench

Two-port arbiter and sequencer for the single-port data RAM (DS), sharing it between the CPU core (port 0) and a loader/debug master (port 1). It accepts one request at a time, drives registered address/data/write-enable into the RAM (registered inputs, unregistered output), and returns read data with a done pulse. It sits between the requesters and the `lpm_ram_dq` instance.

---
 rtl/ds_arb_pkg.sv | 14 +
 rtl/ds_arbiter_if.sv | 32 +++
 rtl/rr_pick2.sv | 25 ++
 rtl/ds_arbiter.sv | 139 +++++++++++++
 tb/tb_ds_arbiter.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ds_arb_pkg.sv
// Shared types and defaults for the DS RAM arbiter.
// The FSM state encoding is also visible on the o_state observer port.
package ds_arb_pkg;

    localparam int AW_DEF = 16;
    localparam int DW_DEF = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/ds_arbiter_if.sv
// Requester-side bus of the DS arbiter: two request ports plus the shared read data.
// master = requesters (CPU core / loader), slave = arbiter.
interface ds_arbiter_if
    import ds_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
);
    logic          req0;
    logic          req1;
    logic          we0;
    logic          we1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wd0;
    logic [DW-1:0] wd1;
    logic          gnt0;
    logic          gnt1;
    logic          done0;
    logic          done1;
    logic [DW-1:0] rdata;

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wd0, wd1,
        input  gnt0, gnt1, done0, done1, rdata
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wd0, wd1,
        output gnt0, gnt1, done0, done1, rdata
    );
endinterface

// File: rtl/rr_pick2.sv
// Combinational two-way picker: lone requester wins; on a tie either port 0
// (fixed priority) or the port not granted last (round-robin).
module rr_pick2
    import ds_arb_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_last,
    output logic o_win,
    output logic o_valid
);

    always_comb begin
        o_valid = i_req0 | i_req1;
        o_win   = 1'b0;
        if (i_req0 && i_req1) begin
            o_win = FIXED_PRIO ? 1'b0 : ~i_last;
        end else begin
            o_win = i_req1;
        end
    end

endmodule

// File: rtl/ds_arbiter.sv
// Two-port arbiter/sequencer for the single-port data RAM (registered-input,
// unregistered-output RAM). One access in flight; IDLE -> ACCESS -> DONE.
module ds_arbiter
    import ds_arb_pkg::*;
#(
    parameter int AW         = AW_DEF,
    parameter int DW         = DW_DEF,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic          clock,
    input  logic          reset,
    ds_arbiter_if.slave   bus,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wd,
    output logic          ram_we,
    input  logic [DW-1:0] ram_q,
    output logic [1:0]    o_state
);

    state_t        r_state;
    state_t        w_state_next;
    logic          w_grant;
    logic          w_win;
    logic          w_valid;
    logic [1:0]    w_req;
    logic [1:0]    w_we;
    logic [AW-1:0] w_addr [2];
    logic [DW-1:0] w_wd   [2];

    logic [AW-1:0] r_ram_addr;
    logic [DW-1:0] r_ram_wd;
    logic          r_ram_we;
    logic          r_owner;
    logic          r_is_read;
    logic          r_last;
    logic [1:0]    r_gnt;
    logic [1:0]    r_done;
    logic [DW-1:0] r_rdata;

    assign w_req     = {bus.req1, bus.req0};
    assign w_we      = {bus.we1, bus.we0};
    assign w_addr[0] = bus.addr0;
    assign w_addr[1] = bus.addr1;
    assign w_wd[0]   = bus.wd0;
    assign w_wd[1]   = bus.wd1;

    rr_pick2 #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_pick (
        .i_req0  (w_req[0]),
        .i_req1  (w_req[1]),
        .i_last  (r_last),
        .o_win   (w_win),
        .o_valid (w_valid)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_grant      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_valid) begin
                    w_grant      = 1'b1;
                    w_state_next = ACCESS;
                end
            end
            ACCESS: begin
                w_state_next = DONE;
            end
            DONE: begin
                // Re-arbitrate here so a held request runs back-to-back.
                if (w_valid) begin
                    w_grant      = 1'b1;
                    w_state_next = ACCESS;
                end else begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ram_addr <= '0;
            r_ram_wd   <= '0;
            r_ram_we   <= 1'b0;
            r_owner    <= 1'b0;
            r_is_read  <= 1'b0;
            r_last     <= 1'b1;
            r_gnt      <= '0;
            r_done     <= '0;
            r_rdata    <= '0;
        end else begin
            r_gnt  <= '0;
            r_done <= '0;
            if (w_grant) begin
                r_ram_addr   <= w_addr[w_win];
                r_ram_wd     <= w_wd[w_win];
                r_ram_we     <= w_we[w_win];
                r_is_read    <= ~w_we[w_win];
                r_owner      <= w_win;
                r_last       <= w_win;
                r_gnt[w_win] <= 1'b1;
            end
            // RAM latches addr/we on the edge leaving ACCESS; write is committed there.
            if (r_state == ACCESS) begin
                r_ram_we        <= 1'b0;
                r_done[r_owner] <= 1'b1;
            end
            if (r_state == DONE && r_is_read) begin
                r_rdata <= ram_q;
            end
        end
    end

    // RAM output is unregistered, so during a read's done cycle the data is
    // forwarded straight from ram_q; the held copy covers every other cycle.
    assign bus.rdata = ((|r_done) && r_is_read) ? ram_q : r_rdata;
    assign bus.gnt0  = r_gnt[0];
    assign bus.gnt1  = r_gnt[1];
    assign bus.done0 = r_done[0];
    assign bus.done1 = r_done[1];
    assign ram_addr  = r_ram_addr;
    assign ram_wd    = r_ram_wd;
    assign ram_we    = r_ram_we;
    assign o_state   = r_state;

endmodule

// File: tb/tb_ds_arbiter.sv
// Directed bench for ds_arbiter: round-robin instance with a behavioural RAM,
// plus a fixed-priority instance with an address-derived read model.
module tb_ds_arbiter;
    import ds_arb_pkg::*;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    ds_arbiter_if #(.AW(16), .DW(16)) bus ();
    ds_arbiter_if #(.AW(16), .DW(16)) bus_f ();

    logic [15:0] ram_addr, ram_wd, ram_q;
    logic        ram_we;
    logic [1:0]  state_a;
    logic [15:0] f_addr, f_wd, f_q;
    logic        f_we;
    logic [1:0]  state_f;

    ds_arbiter #(.AW(16), .DW(16), .FIXED_PRIO(1'b0)) dut (
        .clock    (clock),
        .reset    (reset),
        .bus      (bus),
        .ram_addr (ram_addr),
        .ram_wd   (ram_wd),
        .ram_we   (ram_we),
        .ram_q    (ram_q),
        .o_state  (state_a)
    );

    ds_arbiter #(.AW(16), .DW(16), .FIXED_PRIO(1'b1)) dut_f (
        .clock    (clock),
        .reset    (reset),
        .bus      (bus_f),
        .ram_addr (f_addr),
        .ram_wd   (f_wd),
        .ram_we   (f_we),
        .ram_q    (f_q),
        .o_state  (state_f)
    );

    // RAM model: registered address/data/we, unregistered output.
    logic [15:0] mem [0:65535];
    logic [15:0] lat_addr = 16'h0;
    logic        pl_en    = 1'b0;
    logic [15:0] pl_addr  = 16'h0;
    logic [15:0] pl_data  = 16'h0;
    always @(posedge clock) begin
        lat_addr <= ram_addr;
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (ram_we) mem[ram_addr] <= ram_wd;
    end
    assign ram_q = mem[lat_addr];

    logic [15:0] f_lat = 16'h0;
    always @(posedge clock) f_lat <= f_addr;
    assign f_q = f_lat ^ 16'hA5A5;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    task automatic preload(input logic [15:0] a, input logic [15:0] d);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        step();
        pl_en   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
        bus.addr0 = 0; bus.addr1 = 0; bus.wd0 = 0; bus.wd1 = 0;
        bus_f.req0 = 0; bus_f.req1 = 0; bus_f.we0 = 0; bus_f.we1 = 0;
        bus_f.addr0 = 16'h0010; bus_f.addr1 = 16'h0020; bus_f.wd0 = 0; bus_f.wd1 = 0;
        step();
        preload(16'h0012, 16'hBEEF);
        preload(16'h0001, 16'h1111);
        preload(16'h0002, 16'h2222);
        preload(16'h0003, 16'h3333);
        preload(16'h0050, 16'h5555);
        preload(16'h0005, 16'h0123);

        // Reset state
        check_eq("rst_state", {30'd0, state_a}, 32'd0);
        check_eq("rst_gnt_done", {28'd0, bus.gnt1, bus.gnt0, bus.done1, bus.done0}, 32'd0);
        check_eq("rst_ram", {15'd0, ram_we, ram_addr}, 32'd0);
        check_eq("rst_wd_rdata", {ram_wd, bus.rdata}, 32'd0);
        reset = 1'b1;
        step();
        check_eq("idle_state", {30'd0, state_a}, 32'd0);

        // Single read of 0x0012
        $display("txn read p0 addr=0012");
        bus.req0 = 1; bus.we0 = 0; bus.addr0 = 16'h0012;
        step();
        check_eq("rd_gnt", {30'd0, bus.gnt1, bus.gnt0}, 32'd1);
        check_eq("rd_state1", {30'd0, state_a}, 32'd1);
        check_eq("rd_addr", {16'd0, ram_addr}, 32'h12);
        bus.req0 = 0;
        step();
        check_eq("rd_done", {30'd0, bus.done1, bus.done0}, 32'd1);
        check_eq("rd_data", {16'd0, bus.rdata}, 32'hBEEF);
        check_eq("rd_state2", {30'd0, state_a}, 32'd2);
        step();
        check_eq("rd_state0", {30'd0, state_a}, 32'd0);
        check_eq("rd_hold", {15'd0, bus.done0, bus.rdata}, 32'hBEEF);

        // Port 1 write 0x1234 -> 0x0040, then port 0 reads it back-to-back
        $display("txn write p1 addr=0040 data=1234");
        bus.req1 = 1; bus.we1 = 1; bus.addr1 = 16'h0040; bus.wd1 = 16'h1234;
        step();
        check_eq("wr_gnt", {30'd0, bus.gnt1, bus.gnt0}, 32'd2);
        check_eq("wr_we_hi", {15'd0, ram_we, ram_wd}, 32'h11234);
        bus.req1 = 0; bus.we1 = 0;
        step();
        check_eq("wr_done", {30'd0, bus.done1, bus.done0}, 32'd2);
        check_eq("wr_we_lo", {31'd0, ram_we}, 32'd0);
        $display("txn read p0 addr=0040");
        bus.req0 = 1; bus.we0 = 0; bus.addr0 = 16'h0040;
        step();
        check_eq("wr_rd_gnt", {29'd0, ram_we, bus.gnt1, bus.gnt0}, 32'd1);
        bus.req0 = 0;
        step();
        check_eq("wr_rd_done", {30'd0, bus.done1, bus.done0}, 32'd1);
        check_eq("wr_rd_data", {16'd0, bus.rdata}, 32'h1234);
        check_eq("wr_mem", {16'd0, mem[16'h0040]}, 32'h1234);
        step();

        // Round-robin contention: port 0 was granted last, so port 1 goes first.
        bus.req0 = 1; bus.we0 = 0; bus.addr0 = 16'h0012;
        bus.req1 = 1; bus.we1 = 0; bus.addr1 = 16'h0040;
        for (int c = 1; c <= 8; c++) begin
            logic w;
            step();
            w = (((c - 1) / 2) % 2) == 0;
            if (c % 2 == 1) begin
                $display("txn rr grant cycle=%0d port=%0d", c, w);
                check_eq("rr_gnt", {30'd0, bus.gnt1, bus.gnt0}, w ? 32'd2 : 32'd1);
                check_eq("rr_state", {30'd0, state_a}, 32'd1);
            end else begin
                check_eq("rr_done", {28'd0, bus.gnt1, bus.gnt0, bus.done1, bus.done0},
                         w ? 32'd2 : 32'd1);
                check_eq("rr_data", {16'd0, bus.rdata}, w ? 32'h1234 : 32'hBEEF);
            end
            if (c == 8) begin
                bus.req0 = 0; bus.req1 = 0;
            end
        end
        step();
        check_eq("rr_idle", {30'd0, state_a}, 32'd0);

        // Fixed priority: port 0 keeps winning while it holds req.
        bus_f.req0 = 1; bus_f.req1 = 1;
        for (int c = 1; c <= 6; c++) begin
            step();
            if (c % 2 == 1) begin
                $display("txn fixed grant cycle=%0d", c);
                check_eq("fp_gnt0", {30'd0, bus_f.gnt1, bus_f.gnt0}, 32'd1);
            end else begin
                check_eq("fp_done0", {30'd0, bus_f.done1, bus_f.done0}, 32'd1);
                check_eq("fp_data0", {16'd0, bus_f.rdata}, 32'hA5B5);
            end
            if (c == 6) bus_f.req0 = 0;
        end
        step();
        check_eq("fp_gnt1", {30'd0, bus_f.gnt1, bus_f.gnt0}, 32'd2);
        bus_f.req1 = 0;
        step();
        check_eq("fp_done1", {30'd0, bus_f.done1, bus_f.done0}, 32'd2);
        check_eq("fp_data1", {16'd0, bus_f.rdata}, 32'hA585);
        step();
        check_eq("fp_idle", {30'd0, state_f}, 32'd0);

        // Back-to-back reads at 1,2,3 with req0 held
        bus.req0 = 1; bus.we0 = 0; bus.addr0 = 16'h0001;
        for (int c = 1; c <= 6; c++) begin
            int k;
            step();
            k = (c - 1) / 2;
            if (c % 2 == 1) begin
                $display("txn b2b read addr=%0d", k + 1);
                check_eq("b2b_gnt", {28'd0, state_a, bus.gnt1, bus.gnt0}, 32'h5);
                if (k < 2) bus.addr0 = 16'(k + 2);
                else bus.req0 = 0;
            end else begin
                check_eq("b2b_done", {28'd0, state_a, bus.done1, bus.done0}, 32'h9);
                check_eq("b2b_data", {16'd0, bus.rdata}, 32'h1111 * (k + 1));
            end
        end
        step();
        check_eq("b2b_idle", {30'd0, state_a}, 32'd0);

        // Read 0x5555, then a write: rdata must hold through the write's done.
        $display("txn read p1 addr=0050 then write p0 addr=0060");
        bus.req1 = 1; bus.we1 = 0; bus.addr1 = 16'h0050;
        step();
        check_eq("hold_gnt1", {30'd0, bus.gnt1, bus.gnt0}, 32'd2);
        bus.req1 = 0;
        step();
        check_eq("hold_rd", {16'd0, bus.rdata}, 32'h5555);
        bus.req0 = 1; bus.we0 = 1; bus.addr0 = 16'h0060; bus.wd0 = 16'h7777;
        step();
        check_eq("hold_wgnt", {29'd0, ram_we, bus.gnt1, bus.gnt0}, 32'd5);
        bus.req0 = 0; bus.we0 = 0;
        step();
        check_eq("hold_wdone", {30'd0, bus.done1, bus.done0}, 32'd1);
        check_eq("hold_rdata", {16'd0, bus.rdata}, 32'h5555);
        check_eq("hold_mem", {16'd0, mem[16'h0060]}, 32'h7777);
        step();

        // Reset during ACCESS of a write: aborted, no commit, no done.
        $display("txn write p0 addr=0005 data=AAAA aborted by reset");
        bus.req0 = 1; bus.we0 = 1; bus.addr0 = 16'h0005; bus.wd0 = 16'hAAAA;
        step();
        check_eq("ab_access", {29'd0, ram_we, state_a}, 32'h5);
        bus.req0 = 0; bus.we0 = 0;
        #1 reset = 1'b0;
        #1;
        check_eq("ab_we_drop", {31'd0, ram_we}, 32'd0);
        check_eq("ab_outs0", {ram_addr, ram_wd}, 32'd0);
        check_eq("ab_outs1", {10'd0, state_a, bus.gnt1, bus.gnt0, bus.done1, bus.done0, bus.rdata}, 32'd0);
        step();
        check_eq("ab_mem", {16'd0, mem[16'h0005]}, 32'h0123);
        check_eq("ab_nodone", {28'd0, state_a, bus.done1, bus.done0}, 32'd0);
        reset = 1'b1;
        step();
        check_eq("ab_after", {28'd0, state_a, bus.done1, bus.done0}, 32'd0);
        check_eq("ab_mem2", {16'd0, mem[16'h0005]}, 32'h0123);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
